// File: rtl/tag_queue_manager_pkg.sv
// Shared sizing, FSM encodings and queue-index helper for the tag queue manager.
package tag_queue_manager_pkg;

    localparam int MAX_HOST_NUMBER    = 32;
    localparam int MAX_PLANE_NUMBER   = 32;
    localparam int NO_OF_TAG          = 64;
    localparam int HOST_ID_BIT_WIDTH  = $clog2(MAX_HOST_NUMBER);
    localparam int PLANE_ID_BIT_WIDTH = $clog2(MAX_PLANE_NUMBER);
    localparam int TAG_BIT_WIDTH      = $clog2(NO_OF_TAG);
    localparam int NUM_QUEUES         = MAX_HOST_NUMBER * MAX_PLANE_NUMBER;
    localparam int QUEUE_ID_BIT_WIDTH = $clog2(NUM_QUEUES);
    localparam int COUNT_BIT_WIDTH    = $clog2(NO_OF_TAG + 1);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_ENQ    = 4'b0010,
        ST_NOTIFY = 4'b0100,
        ST_DEQ    = 4'b1000
    } state_e;

    function automatic logic [QUEUE_ID_BIT_WIDTH-1:0] queue_index(
        input logic [HOST_ID_BIT_WIDTH-1:0]  host,
        input logic [PLANE_ID_BIT_WIDTH-1:0] plane
    );
        return QUEUE_ID_BIT_WIDTH'(plane) * QUEUE_ID_BIT_WIDTH'(MAX_HOST_NUMBER)
             + QUEUE_ID_BIT_WIDTH'(host);
    endfunction

endpackage

// File: rtl/tag_free_list.sv
// Free-tag bitmap: lowest-free allocation, same-cycle release, sticky double-free flag.
module tag_free_list
    import tag_queue_manager_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_alloc,
    input  logic                     i_release_valid,
    input  logic [TAG_BIT_WIDTH-1:0] i_release_tag,
    output logic [TAG_BIT_WIDTH-1:0] o_free_tag,
    output logic                     o_any_free,
    output logic                     o_double_free
);

    logic [NO_OF_TAG-1:0] free_map;
    logic [NO_OF_TAG-1:0] alloc_mask;
    logic [NO_OF_TAG-1:0] release_mask;
    logic                 release_hits_free;

    always_comb begin
        o_free_tag = '0;
        for (int i = NO_OF_TAG - 1; i >= 0; i--) begin
            if (free_map[i]) o_free_tag = TAG_BIT_WIDTH'(i);
        end
    end

    assign o_any_free        = |free_map;
    assign release_hits_free = i_release_valid && free_map[i_release_tag];
    assign alloc_mask        = i_alloc ? (NO_OF_TAG'(1) << o_free_tag) : '0;
    // A release of an already-free tag is ignored apart from raising the error.
    assign release_mask      = (i_release_valid && !release_hits_free)
                             ? (NO_OF_TAG'(1) << i_release_tag) : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            free_map      <= '1;
            o_double_free <= 1'b0;
        end else begin
            free_map <= (free_map & ~alloc_mask) | release_mask;
            if (release_hits_free) o_double_free <= 1'b1;
        end
    end

endmodule

// File: rtl/tag_queue_manager.sv
// Allocates tags to host commands, keeps per-(host,plane) linked-list FIFOs and dispatches on grant.
//   state  | meaning
//   IDLE   | wait for a pending grant (priority) or a command handshake
//   ENQ    | append latched tag to its queue, bump count
//   NOTIFY | insert pulse to scheduler
//   DEQ    | dispatch registered on entry; pop head, clear pending grant
module tag_queue_manager
    import tag_queue_manager_pkg::*;
(
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,
    input  logic [HOST_ID_BIT_WIDTH-1:0]  i_cmd_host_id,
    input  logic [PLANE_ID_BIT_WIDTH-1:0] i_cmd_plane_id,
    output logic [TAG_BIT_WIDTH-1:0]      o_cmd_tag,
    output logic                          o_insert_req,
    output logic [HOST_ID_BIT_WIDTH-1:0]  o_host_id,
    output logic [PLANE_ID_BIT_WIDTH-1:0] o_plane_id,
    input  logic                          i_grant_valid,
    input  logic [HOST_ID_BIT_WIDTH-1:0]  i_grant_host_id,
    input  logic [PLANE_ID_BIT_WIDTH-1:0] i_grant_plane_id,
    output logic                          o_disp_valid,
    output logic [TAG_BIT_WIDTH-1:0]      o_disp_tag,
    output logic [HOST_ID_BIT_WIDTH-1:0]  o_disp_host_id,
    output logic [PLANE_ID_BIT_WIDTH-1:0] o_disp_plane_id,
    input  logic                          i_release_valid,
    input  logic [TAG_BIT_WIDTH-1:0]      i_release_tag,
    output logic [2:0]                    o_err
);

    state_e                          state;
    logic                            grant_pend;
    logic [HOST_ID_BIT_WIDTH-1:0]    grant_host;
    logic [PLANE_ID_BIT_WIDTH-1:0]   grant_plane;
    logic [TAG_BIT_WIDTH-1:0]        cmd_tag;
    logic [HOST_ID_BIT_WIDTH-1:0]    cmd_host;
    logic [PLANE_ID_BIT_WIDTH-1:0]   cmd_plane;
    logic [QUEUE_ID_BIT_WIDTH-1:0]   q_cmd;
    logic [QUEUE_ID_BIT_WIDTH-1:0]   q_grant;
    logic                            cmd_fire;
    logic [TAG_BIT_WIDTH-1:0]        free_tag;
    logic                            any_free;
    logic                            double_free;
    logic                            err_empty;
    logic                            err_ovf;

    logic [TAG_BIT_WIDTH-1:0]   q_head   [NUM_QUEUES];
    logic [TAG_BIT_WIDTH-1:0]   q_tail   [NUM_QUEUES];
    logic [TAG_BIT_WIDTH-1:0]   next_tag [NO_OF_TAG];
    logic [COUNT_BIT_WIDTH-1:0] q_count  [NUM_QUEUES];

    tag_free_list u_free_list (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_alloc         (cmd_fire),
        .i_release_valid (i_release_valid),
        .i_release_tag   (i_release_tag),
        .o_free_tag      (free_tag),
        .o_any_free      (any_free),
        .o_double_free   (double_free)
    );

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign o_cmd_ready = i_rst_n && (state == ST_IDLE) && !grant_pend && !i_grant_valid && any_free;
    assign o_cmd_tag   = free_tag;
    assign cmd_fire    = o_cmd_ready && i_cmd_valid;
    assign q_cmd       = queue_index(cmd_host, cmd_plane);
    assign q_grant     = queue_index(grant_host, grant_plane);
    assign o_err       = {double_free, err_ovf, err_empty};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= ST_IDLE;
            grant_pend      <= 1'b0;
            grant_host      <= '0;
            grant_plane     <= '0;
            cmd_tag         <= '0;
            cmd_host        <= '0;
            cmd_plane       <= '0;
            o_insert_req    <= 1'b0;
            o_host_id       <= '0;
            o_plane_id      <= '0;
            o_disp_valid    <= 1'b0;
            o_disp_tag      <= '0;
            o_disp_host_id  <= '0;
            o_disp_plane_id <= '0;
            err_empty       <= 1'b0;
            err_ovf         <= 1'b0;
            for (int i = 0; i < NUM_QUEUES; i++) q_count[i] <= '0;
        end else begin
            o_insert_req <= 1'b0;
            o_disp_valid <= 1'b0;
            if (state == ST_DEQ) grant_pend <= 1'b0;
            // A grant arriving while one is still pending (including during DEQ) is lost.
            if (i_grant_valid) begin
                if (grant_pend) begin
                    err_ovf <= 1'b1;
                end else begin
                    grant_pend  <= 1'b1;
                    grant_host  <= i_grant_host_id;
                    grant_plane <= i_grant_plane_id;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (grant_pend) begin
                        if (q_count[q_grant] == '0) begin
                            err_empty <= 1'b1;
                        end else begin
                            o_disp_valid    <= 1'b1;
                            o_disp_tag      <= q_head[q_grant];
                            o_disp_host_id  <= grant_host;
                            o_disp_plane_id <= grant_plane;
                        end
                        state <= ST_DEQ;
                    end else if (cmd_fire) begin
                        cmd_tag   <= free_tag;
                        cmd_host  <= i_cmd_host_id;
                        cmd_plane <= i_cmd_plane_id;
                        state     <= ST_ENQ;
                    end
                end
                ST_ENQ: begin
                    q_count[q_cmd] <= q_count[q_cmd] + COUNT_BIT_WIDTH'(1);
                    o_insert_req   <= 1'b1;
                    o_host_id      <= cmd_host;
                    o_plane_id     <= cmd_plane;
                    state          <= ST_NOTIFY;
                end
                ST_NOTIFY: state <= ST_IDLE;
                ST_DEQ: begin
                    if (q_count[q_grant] != '0)
                        q_count[q_grant] <= q_count[q_grant] - COUNT_BIT_WIDTH'(1);
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Link pointers need no reset: they are only read behind a non-zero count.
    always_ff @(posedge i_clk) begin
        if (state == ST_ENQ) begin
            if (q_count[q_cmd] == '0) q_head[q_cmd] <= cmd_tag;
            else                      next_tag[q_tail[q_cmd]] <= cmd_tag;
            q_tail[q_cmd] <= cmd_tag;
        end else if (state == ST_DEQ && q_count[q_grant] != '0) begin
            q_head[q_grant] <= next_tag[q_head[q_grant]];
        end
    end

endmodule
